// File: rtl/forwarding_scoreboard_pkg.sv
// Shared types for the hazard/forwarding controller: scoreboard entry layout,
// update-mode encoding and the forward-select width helper.
package hazard_pkg;

  localparam int HZ_NSRC  = 2;
  localparam int HZ_REG_W = 5;

  typedef struct packed {
    logic                               valid;
    logic [HZ_REG_W-1:0]                wsel;
    logic                               wen;
    logic                               load;
    logic [HZ_NSRC-1:0][HZ_REG_W-1:0]   rs;
    logic [HZ_NSRC-1:0]                 ruse;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // Select value 0 always means "take the operand from the register file".
  typedef enum logic [0:0] {
    FWD_RF    = 1'b0,
    FWD_STAGE = 1'b1
  } fwd_src_e;

  typedef enum logic [1:0] {
    UPD_HOLD,
    UPD_FLUSH,
    UPD_BUBBLE,
    UPD_SHIFT
  } upd_mode_e;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/forwarding_scoreboard_fwd_match.sv
// Per-source hazard lookup: youngest-producer forward select for the EX consumer
// and a flag for a decode source that depends on a not-yet-forwardable load.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = 2
) (
  input  logic [DEPTH-1:0]            st_valid,
  input  logic [DEPTH-1:0]            st_wen,
  input  logic [DEPTH-1:0]            st_load,
  input  logic [DEPTH-1:0][REG_W-1:0] st_wsel,
  input  logic [REG_W-1:0]            cons_rs,
  input  logic                        cons_ruse,
  input  logic [REG_W-1:0]            dec_rs,
  input  logic                        dec_ruse,
  output logic [SEL_W-1:0]            fwd_sel,
  output logic                        load_pend
);

  logic [DEPTH-1:1] cons_hit;
  logic [DEPTH-1:0] dec_hit;
  logic [DEPTH-1:0] early;

  always_comb begin
    cons_hit = '0;
    dec_hit  = '0;
    early    = '0;
    for (int s = 1; s < DEPTH; s++) begin
      cons_hit[s] = st_valid[s] & st_wen[s] & cons_ruse &
                    (st_wsel[s] != '0) & (st_wsel[s] == cons_rs);
    end
    // A load at index s is consumed from stage s+2 next cycle; too early if s < LOAD_LAT.
    for (int s = 0; s < DEPTH; s++) begin
      dec_hit[s] = st_valid[s] & st_wen[s] & dec_ruse &
                   (st_wsel[s] != '0) & (st_wsel[s] == dec_rs);
      early[s]   = (s < LOAD_LAT);
    end
  end

  always_comb begin
    fwd_sel = SEL_W'(FWD_RF);
    for (int s = DEPTH - 1; s >= 1; s--) begin
      if (cons_hit[s]) fwd_sel = SEL_W'(s + 1);
    end
    load_pend = |(dec_hit & st_load & early);
  end

endmodule

// File: rtl/forwarding_scoreboard.sv
// Hazard/forwarding controller: DEPTH-stage destination scoreboard, per-source
// forward selects, load-use stall and a saturating stall-cycle counter.
module forwarding_scoreboard
  import hazard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int NSRC     = HZ_NSRC,
  parameter int REG_W    = HZ_REG_W,
  parameter int LOAD_LAT = 1,
  parameter int FLUSH_N  = 1,
  parameter int CNT_W    = 16,
  localparam int SEL_W   = sel_w(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic [NSRC*REG_W-1:0] id_rs,
  input  logic [NSRC-1:0]       id_ruse,
  input  logic [REG_W-1:0]      id_wsel,
  input  logic                  id_wen,
  input  logic                  id_load,
  output logic                  stall,
  output logic [NSRC*SEL_W-1:0] fwd_sel,
  output logic [CNT_W-1:0]      stall_count,
  input  logic                  cnt_clr
);

  sb_entry_t sb_q [DEPTH];
  sb_entry_t sb_d [DEPTH];
  sb_entry_t id_entry;

  logic [DEPTH-1:0]            st_valid;
  logic [DEPTH-1:0]            st_wen;
  logic [DEPTH-1:0]            st_load;
  logic [DEPTH-1:0][REG_W-1:0] st_wsel;
  logic [NSRC-1:0]             load_pend;
  upd_mode_e                   upd_mode;
  logic [CNT_W-1:0]            cnt_q;
  logic [CNT_W-1:0]            cnt_d;

  always_comb begin
    st_valid = '0;
    st_wen   = '0;
    st_load  = '0;
    st_wsel  = '0;
    for (int s = 0; s < DEPTH; s++) begin
      st_valid[s] = sb_q[s].valid;
      st_wen[s]   = sb_q[s].wen;
      st_load[s]  = sb_q[s].load;
      st_wsel[s]  = sb_q[s].wsel;
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_match #(
      .DEPTH   (DEPTH),
      .REG_W   (REG_W),
      .LOAD_LAT(LOAD_LAT),
      .SEL_W   (SEL_W)
    ) u_match (
      .st_valid (st_valid),
      .st_wen   (st_wen),
      .st_load  (st_load),
      .st_wsel  (st_wsel),
      .cons_rs  (sb_q[0].rs[i]),
      .cons_ruse(sb_q[0].valid & sb_q[0].ruse[i]),
      .dec_rs   (id_rs[i*REG_W +: REG_W]),
      .dec_ruse (id_ruse[i]),
      .fwd_sel  (fwd_sel[i*SEL_W +: SEL_W]),
      .load_pend(load_pend[i])
    );
  end

  // A taken branch kills the decode instruction, so it never needs to wait.
  always_comb begin
    stall = (|load_pend) & ~flush;
    if (freeze || !en)  upd_mode = UPD_HOLD;
    else if (flush)     upd_mode = UPD_FLUSH;
    else if (stall)     upd_mode = UPD_BUBBLE;
    else                upd_mode = UPD_SHIFT;
  end

  always_comb begin
    id_entry       = SB_BUBBLE;
    id_entry.valid = 1'b1;
    id_entry.wsel  = id_wsel;
    id_entry.wen   = id_wen;
    id_entry.load  = id_load;
    id_entry.rs    = id_rs;
    id_entry.ruse  = id_ruse;
    for (int s = 0; s < DEPTH; s++) sb_d[s] = sb_q[s];
    if (upd_mode != UPD_HOLD) begin
      for (int s = 1; s < DEPTH; s++) sb_d[s] = sb_q[s-1];
      sb_d[0] = (upd_mode == UPD_SHIFT) ? id_entry : SB_BUBBLE;
      if (upd_mode == UPD_FLUSH) begin
        for (int s = 1; s < DEPTH; s++) begin
          if (s <= FLUSH_N) sb_d[s] = SB_BUBBLE;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) cnt_d = '0;
    else if (stall && en && !freeze && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < DEPTH; s++) sb_q[s] <= SB_BUBBLE;
      cnt_q <= '0;
    end else begin
      for (int s = 0; s < DEPTH; s++) sb_q[s] <= sb_d[s];
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Bench for forwarding_scoreboard: a default instance and a DEPTH=4/LOAD_LAT=2/CNT_W=4
// instance share stimulus; directed scenarios plus random traffic against a pipeline model.
module tb_forwarding_scoreboard;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        en = 1'b1, freeze = 1'b0, flush = 1'b0, cnt_clr = 1'b0;
  logic [9:0]  id_rs = '0;
  logic [1:0]  id_ruse = '0;
  logic [4:0]  id_wsel = '0;
  logic        id_wen = 1'b0, id_load = 1'b0;
  logic        a_stall, b_stall;
  logic [3:0]  a_sel;
  logic [5:0]  b_sel;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  forwarding_scoreboard dut_a (
    .CLK(CLK), .RST(RST), .en(en), .freeze(freeze), .flush(flush),
    .id_rs(id_rs), .id_ruse(id_ruse), .id_wsel(id_wsel), .id_wen(id_wen), .id_load(id_load),
    .stall(a_stall), .fwd_sel(a_sel), .stall_count(a_cnt), .cnt_clr(cnt_clr)
  );

  forwarding_scoreboard #(.DEPTH(4), .LOAD_LAT(2), .CNT_W(4)) dut_b (
    .CLK(CLK), .RST(RST), .en(en), .freeze(freeze), .flush(flush),
    .id_rs(id_rs), .id_ruse(id_ruse), .id_wsel(id_wsel), .id_wen(id_wen), .id_load(id_load),
    .stall(b_stall), .fwd_sel(b_sel), .stall_count(b_cnt), .cnt_clr(cnt_clr)
  );

  // Reference model: pipe[k][s-1] is the instruction sitting in stage s of instance k.
  typedef struct packed {
    logic            v;
    logic [4:0]      wsel;
    logic            wen;
    logic            load;
    logic [1:0][4:0] rs;
    logic [1:0]      ru;
  } ins_t;

  localparam int DEPTH_OF [2] = '{3, 4};
  localparam int LAT_OF   [2] = '{1, 2};
  localparam int CMAX     [2] = '{65535, 15};
  localparam int FLUSH_N      = 1;

  ins_t pipe [2][4];
  int   cnt_m [2];

  function automatic bit produces(input ins_t p, input logic [4:0] r);
    return p.v && p.wen && (p.wsel != 5'd0) && (p.wsel == r);
  endfunction

  function automatic int model_fwd(input int k, input int i);
    ins_t c = pipe[k][0];
    if (!(c.v && c.ru[i])) return 0;
    for (int s = 2; s <= DEPTH_OF[k]; s++) begin
      if (produces(pipe[k][s-1], c.rs[i])) return s;
    end
    return 0;
  endfunction

  // Stall when a decode source would next cycle read a load from a stage before it is ready.
  function automatic bit model_stall(input int k);
    if (flush) return 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int s = 1; s <= DEPTH_OF[k]; s++) begin
        if (id_ruse[i] && pipe[k][s-1].load && produces(pipe[k][s-1], id_rs[i*5 +: 5]) &&
            (s + 1 < 2 + LAT_OF[k])) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int dut_sel(input int k, input int i);
    if (k == 0) return int'(a_sel[i*2 +: 2]);
    return int'(b_sel[i*3 +: 3]);
  endfunction

  function automatic int dut_stall(input int k);
    return (k == 0) ? int'(a_stall) : int'(b_stall);
  endfunction

  function automatic int dut_cnt(input int k);
    return (k == 0) ? int'(a_cnt) : int'(b_cnt);
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      cnt_m[k] = 0;
      for (int s = 0; s < 4; s++) pipe[k][s] = '0;
    end
  endtask

  task automatic set_id(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] ru,
                        input logic [4:0] w, input logic we, input logic ld);
    id_rs = {r1, r0}; id_ruse = ru; id_wsel = w; id_wen = we; id_load = ld;
  endtask

  task automatic set_nop();
    set_id(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
  endtask

  // One clock: advance the model with the pre-edge inputs; returns at the next falling edge.
  task automatic tick();
    bit   st [2];
    ins_t nw;
    nw.v = 1'b1; nw.wsel = id_wsel; nw.wen = id_wen; nw.load = id_load; nw.rs = id_rs; nw.ru = id_ruse;
    for (int k = 0; k < 2; k++) st[k] = model_stall(k);
    @(posedge CLK);
    for (int k = 0; k < 2; k++) begin
      if (en && !freeze) begin
        for (int s = DEPTH_OF[k] - 1; s >= 1; s--) pipe[k][s] = pipe[k][s-1];
        if (flush) begin
          pipe[k][0] = '0;
          for (int s = 1; s <= FLUSH_N && s < DEPTH_OF[k]; s++) pipe[k][s] = '0;
        end else if (st[k]) pipe[k][0] = '0;
        else pipe[k][0] = nw;
      end
      if (cnt_clr) cnt_m[k] = 0;
      else if (st[k] && en && !freeze && cnt_m[k] < CMAX[k]) cnt_m[k]++;
    end
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1; en = 1'b1; freeze = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    set_nop();
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++; if (a_stall !== 1'b0) begin n_fail++; $display("FAIL rst_init_a_stall: got %b want 0", a_stall); end
    n_chk++; if (a_sel !== 4'd0) begin n_fail++; $display("FAIL rst_init_a_sel: got %h want 0", a_sel); end
    n_chk++; if (b_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_init_b_cnt: got %0d want 0", b_cnt); end
    set_id(5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0);
    tick();
    #1;
    n_chk++; if (a_cnt !== 16'd1) begin n_fail++; $display("FAIL rst_pre_a_cnt: got %0d want 1", a_cnt); end
    n_chk++; if (b_stall !== 1'b1) begin n_fail++; $display("FAIL rst_pre_b_stall: got %b want 1", b_stall); end
    #1 RST = 1'b1;
    #1;
    n_chk++; if (b_stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_b_stall: got %b want 0", b_stall); end
    n_chk++; if (a_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_mid_a_cnt: got %0d want 0", a_cnt); end
    n_chk++; if (b_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_mid_b_cnt: got %0d want 0", b_cnt); end
    n_chk++; if (b_sel !== 6'd0) begin n_fail++; $display("FAIL rst_mid_b_sel: got %h want 0", b_sel); end
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    clear_model();
  endtask

  task automatic test_fwd_alu();
    do_reset();
    set_id(5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(5'd3, 5'd1, 2'b11, 5'd4, 1'b1, 1'b0);
    tick();
    #1;
    n_chk++; if (a_sel[1:0] !== 2'd2) begin n_fail++; $display("FAIL alu_a_sel0: got %0d want 2", a_sel[1:0]); end
    n_chk++; if (a_sel[3:2] !== 2'd0) begin n_fail++; $display("FAIL alu_a_sel1: got %0d want 0", a_sel[3:2]); end
    n_chk++; if (b_sel !== 6'd2) begin n_fail++; $display("FAIL alu_b_sel: got %h want 02", b_sel); end
    set_id(5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(5'd7, 5'd7, 2'b11, 5'd3, 1'b1, 1'b0);
    tick();
    set_id(5'd3, 5'd0, 2'b01, 5'd4, 1'b1, 1'b0);
    tick();
    set_nop();
    #1;
    n_chk++; if (a_sel !== 4'd2) begin n_fail++; $display("FAIL young_a_sel: got %h want 2", a_sel); end
    n_chk++; if (b_sel !== 6'd2) begin n_fail++; $display("FAIL young_b_sel: got %h want 02", b_sel); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0);
    #1;
    n_chk++; if (a_stall !== 1'b1) begin n_fail++; $display("FAIL lu_a_stall_c1: got %b want 1", a_stall); end
    n_chk++; if (b_stall !== 1'b1) begin n_fail++; $display("FAIL lu_b_stall_c1: got %b want 1", b_stall); end
    tick();
    #1;
    n_chk++; if (a_stall !== 1'b0) begin n_fail++; $display("FAIL lu_a_stall_c2: got %b want 0", a_stall); end
    n_chk++; if (b_stall !== 1'b1) begin n_fail++; $display("FAIL lu_b_stall_c2: got %b want 1", b_stall); end
    n_chk++; if (a_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_a_cnt: got %0d want 1", a_cnt); end
    tick();
    #1;
    n_chk++; if (a_sel !== 4'b1111) begin n_fail++; $display("FAIL lu_a_sel: got %h want f (3,3)", a_sel); end
    n_chk++; if (b_stall !== 1'b0) begin n_fail++; $display("FAIL lu_b_stall_c3: got %b want 0", b_stall); end
    n_chk++; if (b_cnt !== 4'd2) begin n_fail++; $display("FAIL lu_b_cnt: got %0d want 2", b_cnt); end
    tick();
    set_nop();
    #1;
    n_chk++; if (b_sel !== 6'b100100) begin n_fail++; $display("FAIL lu_b_sel: got %h want 24 (4,4)", b_sel); end
  endtask

  task automatic test_r0();
    do_reset();
    set_id(5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1);
    tick();
    set_id(5'd0, 5'd0, 2'b11, 5'd6, 1'b1, 1'b0);
    #1;
    n_chk++; if (a_stall !== 1'b0) begin n_fail++; $display("FAIL r0_a_stall: got %b want 0", a_stall); end
    n_chk++; if (b_stall !== 1'b0) begin n_fail++; $display("FAIL r0_b_stall: got %b want 0", b_stall); end
    tick();
    set_nop();
    #1;
    n_chk++; if (a_sel !== 4'd0) begin n_fail++; $display("FAIL r0_a_sel: got %h want 0", a_sel); end
    n_chk++; if (b_sel !== 6'd0) begin n_fail++; $display("FAIL r0_b_sel: got %h want 0", b_sel); end
  endtask

  task automatic test_freeze_flush();
    do_reset();
    set_id(5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0);
    freeze = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_chk++; if (a_stall !== 1'b1) begin n_fail++; $display("FAIL frz_a_stall c%0d: got %b want 1", c, a_stall); end
      n_chk++; if (a_cnt !== 16'd0) begin n_fail++; $display("FAIL frz_a_cnt c%0d: got %0d want 0", c, a_cnt); end
      n_chk++; if (b_cnt !== 4'd0) begin n_fail++; $display("FAIL frz_b_cnt c%0d: got %0d want 0", c, b_cnt); end
      tick();
    end
    freeze = 1'b0;
    tick();
    #1;
    n_chk++; if (a_cnt !== 16'd1) begin n_fail++; $display("FAIL unfrz_a_cnt: got %0d want 1", a_cnt); end
    n_chk++; if (a_stall !== 1'b0) begin n_fail++; $display("FAIL unfrz_a_stall: got %b want 0", a_stall); end
    do_reset();
    set_id(5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    n_chk++; if (a_stall !== 1'b0) begin n_fail++; $display("FAIL flush_a_stall: got %b want 0", a_stall); end
    n_chk++; if (b_stall !== 1'b0) begin n_fail++; $display("FAIL flush_b_stall: got %b want 0", b_stall); end
    tick();
    flush = 1'b0;
    #1;
    n_chk++; if (a_stall !== 1'b0) begin n_fail++; $display("FAIL postflush_a_stall: got %b want 0", a_stall); end
    n_chk++; if (b_stall !== 1'b0) begin n_fail++; $display("FAIL postflush_b_stall: got %b want 0", b_stall); end
    n_chk++; if (a_cnt !== 16'd0) begin n_fail++; $display("FAIL postflush_a_cnt: got %0d want 0", a_cnt); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int r = 0; r < 10; r++) begin
      set_id(5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1);
      tick();
      set_id(5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0);
      tick();
      tick();
    end
    #1;
    n_chk++; if (b_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_b_cnt: got %0d want 15", b_cnt); end
    n_chk++; if (a_cnt !== 16'd10) begin n_fail++; $display("FAIL sat_a_cnt: got %0d want 10", a_cnt); end
    set_id(5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    #1;
    n_chk++; if (a_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_a_cnt: got %0d want 0", a_cnt); end
    n_chk++; if (b_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_b_cnt: got %0d want 0", b_cnt); end
    set_nop();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      en      = ($urandom_range(0, 9) != 0);
      freeze  = ($urandom_range(0, 9) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      cnt_clr = ($urandom_range(0, 39) == 0);
      set_id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      #1;
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (dut_stall(k) != int'(model_stall(k))) begin
          n_fail++; $display("FAIL rnd_stall k%0d cyc%0d: got %0d want %0d", k, c, dut_stall(k), model_stall(k));
        end
        n_chk++;
        if (dut_cnt(k) != cnt_m[k]) begin
          n_fail++; $display("FAIL rnd_cnt k%0d cyc%0d: got %0d want %0d", k, c, dut_cnt(k), cnt_m[k]);
        end
        for (int i = 0; i < 2; i++) begin
          n_chk++;
          if (dut_sel(k, i) != model_fwd(k, i)) begin
            n_fail++; $display("FAIL rnd_fwd k%0d src%0d cyc%0d: got %0d want %0d", k, i, c, dut_sel(k, i), model_fwd(k, i));
          end
          n_chk++;
          if (dut_sel(k, i) >= 2 && pipe[k][dut_sel(k, i) - 1].load && dut_sel(k, i) < 2 + LAT_OF[k]) begin
            n_fail++; $display("FAIL rnd_unready k%0d src%0d cyc%0d: got stage %0d want >= %0d", k, i, c, dut_sel(k, i), 2 + LAT_OF[k]);
          end
        end
      end
      tick();
    end
    en = 1'b1; freeze = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    clear_model();
    test_reset();
    test_fwd_alu();
    test_load_use();
    test_r0();
    test_freeze_flush();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
